// File: rtl/div_seq.sv
// div_seq: radix-2 restoring signed/unsigned divider with RISC-V M semantics, including W operations.
// Define DIV_SPECIAL_BYPASS_EN to retire divide-by-zero and signed overflow without iterating.
module div_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             is_signed,
    input  logic             is_word,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);
    localparam int HW = WIDTH / 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    N_FULL   = CW'(WIDTH);
    localparam logic [CW-1:0]    N_WORD   = CW'(HW);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_FULL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIN_WORD = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] sext_half(input logic [WIDTH-1:0] v);
        return {{HW{v[HW-1]}}, v[HW-1:0]};
    endfunction

    function automatic logic [WIDTH-1:0] zext_half(input logic [WIDTH-1:0] v);
        return {{HW{1'b0}}, v[HW-1:0]};
    endfunction

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + ONE) : v;
    endfunction

    // Sign fix-up of the magnitudes, special-case override, then word-mode sign extension.
    function automatic logic [2*WIDTH-1:0] finish_result(
        input logic [WIDTH-1:0] q_mag,
        input logic [WIDTH-1:0] r_mag,
        input logic             neg_q,
        input logic             neg_r,
        input logic             div0,
        input logic             ovf,
        input logic             word,
        input logic [WIDTH-1:0] dividend
    );
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        if (div0) begin
            q = '1;
            r = dividend;
        end else if (ovf) begin
            q = word ? MIN_WORD : MIN_FULL;
            r = '0;
        end else begin
            q = negate(q_mag, neg_q);
            r = negate(r_mag, neg_r);
        end
        return word ? {sext_half(q), sext_half(r)} : {q, r};
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    cnt_r;
    logic             word_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             div0_r;
    logic             ovf_r;
    logic [WIDTH-1:0] a_keep_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] prem_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic             out_valid_r;

    logic [WIDTH-1:0] a_ext_s;
    logic [WIDTH-1:0] b_ext_s;
    logic             sign_a_s;
    logic             sign_b_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic             div0_s;
    logic             ovf_s;
    logic             accept_s;
    logic [CW-1:0]    n_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   sub_s;
    logic             qbit_s;
    logic [WIDTH-1:0] prem_next_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign quot      = quot_r;
    assign rem       = rem_r;
    assign accept_s  = in_valid && in_ready && !flush;
    assign n_s       = word_r ? N_WORD : N_FULL;

    // Operand conditioning: extend to the effective width, detect special cases, form magnitudes
    always_comb begin
        a_ext_s = srca;
        b_ext_s = srcb;
        if (is_word) begin
            if (is_signed) begin
                a_ext_s = sext_half(srca);
                b_ext_s = sext_half(srcb);
            end else begin
                a_ext_s = zext_half(srca);
                b_ext_s = zext_half(srcb);
            end
        end else begin
            a_ext_s = srca;
            b_ext_s = srcb;
        end
        sign_a_s = is_signed & a_ext_s[WIDTH-1];
        sign_b_s = is_signed & b_ext_s[WIDTH-1];
        mag_a_s  = negate(a_ext_s, sign_a_s);
        mag_b_s  = negate(b_ext_s, sign_b_s);
        div0_s   = (b_ext_s == '0);
        ovf_s    = is_signed && (a_ext_s == (is_word ? MIN_WORD : MIN_FULL)) && (b_ext_s == '1);
    end

    // One restoring step: the borrow of the (WIDTH+1)-bit trial subtraction is the inverted quotient bit
    always_comb begin
        trial_s     = {prem_r, dvd_r[WIDTH-1]};
        sub_s       = trial_s - {1'b0, dvs_r};
        qbit_s      = ~sub_s[WIDTH];
        prem_next_s = qbit_s ? sub_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush beats both accept and pop
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef DIV_SPECIAL_BYPASS_EN
                    state_next_s = (div0_s || ovf_s) ? DONE : BUSY;
`else
                    state_next_s = BUSY;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else if (cnt_r == n_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (flush || (out_valid_r && out_ready)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand capture, iteration, and result/valid registers; results are held outside DONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r       <= '0;
            word_r      <= 1'b0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            div0_r      <= 1'b0;
            ovf_r       <= 1'b0;
            a_keep_r    <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            prem_r      <= '0;
            quot_r      <= '0;
            rem_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r    <= '0;
            word_r   <= is_word;
            neg_q_r  <= sign_a_s ^ sign_b_s;
            neg_r_r  <= sign_a_s;
            div0_r   <= div0_s;
            ovf_r    <= ovf_s;
            a_keep_r <= a_ext_s;
            dvd_r    <= is_word ? (mag_a_s << HW) : mag_a_s;
            dvs_r    <= mag_b_s;
            prem_r   <= '0;
`ifdef DIV_SPECIAL_BYPASS_EN
            if (div0_s || ovf_s) begin
                {quot_r, rem_r} <= finish_result('0, '0, 1'b0, 1'b0, div0_s, ovf_s, is_word, a_ext_s);
            end
`endif
        end else if (state_r == BUSY) begin
            if (cnt_r == n_s) begin
                {quot_r, rem_r} <= finish_result(word_r ? zext_half(dvd_r) : dvd_r, prem_r,
                                                 neg_q_r, neg_r_r, div0_r, ovf_r, word_r, a_keep_r);
                out_valid_r <= 1'b1;
            end else begin
                prem_r <= prem_next_s;
                dvd_r  <= {dvd_r[WIDTH-2:0], qbit_s};
                cnt_r  <= cnt_r + CNT_ONE;
            end
        end else if (state_r == DONE) begin
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
`ifdef DIV_SPECIAL_BYPASS_EN
            else begin
                out_valid_r <= 1'b1;
            end
`endif
        end
    end

endmodule
